// File: rtl/snes_pkg.sv
// Shared SNES pad definitions: button bit positions, frame geometry,
// emulator state encoding and the frame-word builder.
package snes_pkg;

    localparam int SNES_FRAME_BITS = 16;
    localparam int SNES_USED_BITS  = 12;
    localparam int SNES_CNT_W      = 5;

    localparam int BTN_B      = 14;
    localparam int BTN_Y      = 13;
    localparam int BTN_SELECT = 12;
    localparam int BTN_START  = 11;
    localparam int BTN_UP     = 10;
    localparam int BTN_DOWN   = 9;
    localparam int BTN_LEFT   = 8;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 6;
    localparam int BTN_X      = 5;
    localparam int BTN_L      = 4;
    localparam int BTN_R      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } snes_state_e;

    // Frame bit k carries button (B - k), inverted because the pin is
    // active-low; the four trailing bits always read as released.
    function automatic logic [SNES_FRAME_BITS-1:0] snes_frame(input logic [14:0] btn);
        logic [SNES_FRAME_BITS-1:0] f;
        f = '1;
        for (int k = 0; k < SNES_USED_BITS; k++) begin
            f[k] = ~btn[BTN_B - k];
        end
        return f;
    endfunction

endpackage

// File: rtl/snes_sync_edge.sv
// Multi-stage synchronizer for one console pin, plus a history flop that
// turns level changes into single-cycle rise/fall pulses.
module snes_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RST_LEVEL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    // Next values: shift the pin into the chain, history follows the last stage.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_pin};
        hist_d = sync_q[STAGES-1];
    end

    // Chain and history reset to the pin's idle level so release cannot
    // fabricate an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {STAGES{RST_LEVEL}};
            hist_q <= RST_LEVEL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign o_level = sync_q[STAGES-1];
    assign o_rise  = sync_q[STAGES-1] & ~hist_q;
    assign o_fall  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/snes_pad_emu.sv
// SNES controller emulator: answers the console's latch/clock protocol with
// a 16-bit active-low button frame on o_snes_data.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | count 0, nothing loaded; waits for a latch
// ST_LOAD  | latch high (reloading every cycle) or frame held before bit 1
// ST_SHIFT | 0 < count < 16, shifting on each serial clock rise
// ST_DONE  | count 16, data parked at the fill level
module snes_pad_emu
    import snes_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL_LEVEL  = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [14:0]           i_btn_state,
    input  logic                  i_snes_latch,
    input  logic                  i_snes_clk,
    output logic                  o_snes_data,
    output logic                  o_latch_pls,
    output logic                  o_frame_done,
    output logic [SNES_CNT_W-1:0] o_bit_cnt
);

    logic latch_lvl, latch_rise, latch_fall_unused;
    logic clk_lvl_unused, clk_rise, clk_fall_unused;
    logic [2:0] btn_pad_unused;

    assign btn_pad_unused = i_btn_state[2:0];

    snes_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RST_LEVEL (1'b0)
    ) u_sync_latch (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pin   (i_snes_latch),
        .o_level (latch_lvl),
        .o_rise  (latch_rise),
        .o_fall  (latch_fall_unused)
    );

    snes_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RST_LEVEL (1'b1)
    ) u_sync_clk (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pin   (i_snes_clk),
        .o_level (clk_lvl_unused),
        .o_rise  (clk_rise),
        .o_fall  (clk_fall_unused)
    );

    snes_state_e                state_q, state_d;
    logic [SNES_FRAME_BITS-1:0] shift_q, shift_d;
    logic [SNES_CNT_W-1:0]      cnt_q, cnt_d;
    logic                       data_q, data_d;
    logic                       latch_pls_q, latch_pls_d;
    logic                       frame_done_q, frame_done_d;

    // Next-state: latch level overrides everything; clock rises shift only
    // once a frame is loaded and not yet exhausted.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        data_d       = shift_q[0];
        latch_pls_d  = latch_rise;
        frame_done_d = 1'b0;

        if (latch_lvl) begin
            state_d = ST_LOAD;
            shift_d = snes_frame(i_btn_state);
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD, ST_SHIFT: begin
                    if (clk_rise) begin
                        shift_d = {FILL_LEVEL, shift_q[SNES_FRAME_BITS-1:1]};
                        cnt_d   = cnt_q + 5'd1;
                        if (cnt_q == 5'(SNES_FRAME_BITS - 1)) begin
                            state_d      = ST_DONE;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and output registers; data pin is one cycle behind the shifter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '1;
            cnt_q        <= '0;
            data_q       <= 1'b1;
            latch_pls_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            latch_pls_q  <= latch_pls_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_snes_data  = data_q;
    assign o_latch_pls  = latch_pls_q;
    assign o_frame_done = frame_done_q;
    assign o_bit_cnt    = cnt_q;

endmodule

// File: tb/tb_snes_pad_emu.sv
// Directed bench for snes_pad_emu: console protocol driven from one
// initial block, outputs checked against hand-computed values.
module tb_snes_pad_emu;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [14:0] i_btn_state = '0;
    logic        i_snes_latch = 1'b0;
    logic        i_snes_clk = 1'b1;
    logic        o_snes_data;
    logic        o_latch_pls;
    logic        o_frame_done;
    logic [4:0]  o_bit_cnt;

    int vectors = 0;
    int miscompares = 0;
    int done_pulses = 0;
    int latch_pulses = 0;

    snes_pad_emu #(
        .SYNC_STAGES (2),
        .FILL_LEVEL  (1'b0)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_btn_state  (i_btn_state),
        .i_snes_latch (i_snes_latch),
        .i_snes_clk   (i_snes_clk),
        .o_snes_data  (o_snes_data),
        .o_latch_pls  (o_latch_pls),
        .o_frame_done (o_frame_done),
        .o_bit_cnt    (o_bit_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Pulse counters sampled on the falling edge.
    always @(negedge i_clk) begin
        if (o_frame_done === 1'b1) done_pulses++;
        if (o_latch_pls === 1'b1) latch_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic latch_pulse();
        i_snes_latch = 1'b1;
        tick(8);
        i_snes_latch = 1'b0;
        tick(8);
    endtask

    task automatic clk_pulse();
        i_snes_clk = 1'b0;
        tick(8);
        i_snes_clk = 1'b1;
        tick(8);
    endtask

    logic [15:0] frame_bits;
    logic [14:0] host_word;
    int          done_base;
    int          latch_base;

    initial begin
        tick(3);
        chk("rst_data", {31'd0, o_snes_data}, 32'd1);
        chk("rst_cnt", {27'd0, o_bit_cnt}, 32'd0);
        chk("rst_latch_pls", {31'd0, o_latch_pls}, 32'd0);
        chk("rst_frame_done", {31'd0, o_frame_done}, 32'd0);
        i_rst = 1'b0;
        tick(10);
        chk("rst_release_no_latch_pls", latch_pulses, 0);

        // B only: bit 0 low, everything else high, then fill.
        i_btn_state = 15'h4000;
        done_base   = done_pulses;
        latch_base  = latch_pulses;
        latch_pulse();
        chk("b_latch_pls_once", latch_pulses - latch_base, 1);
        chk("b_bit0", {31'd0, o_snes_data}, 32'd0);
        chk("b_cnt0", {27'd0, o_bit_cnt}, 32'd0);
        // First clock: count moves at SYNC_STAGES+1, data at SYNC_STAGES+2.
        i_snes_clk = 1'b0;
        tick(8);
        i_snes_clk = 1'b1;
        tick(3);
        chk("lat_cnt_early", {27'd0, o_bit_cnt}, 32'd1);
        chk("lat_data_early", {31'd0, o_snes_data}, 32'd0);
        tick(1);
        chk("lat_data_on_time", {31'd0, o_snes_data}, 32'd1);
        tick(4);
        for (int k = 2; k <= 16; k++) begin
            clk_pulse();
            chk($sformatf("b_bit%0d", k), {31'd0, o_snes_data}, (k == 16) ? 32'd0 : 32'd1);
            chk($sformatf("b_cnt%0d", k), {27'd0, o_bit_cnt}, k);
        end
        chk("b_done_once", done_pulses - done_base, 1);

        // Buttons change after the latch falls: frame keeps R pressed, B released.
        i_btn_state = 15'h0008;
        latch_pulse();
        i_btn_state = 15'h4000;
        frame_bits[0] = o_snes_data;
        for (int k = 1; k < 16; k++) begin
            clk_pulse();
            frame_bits[k] = o_snes_data;
        end
        chk("freeze_frame", {16'd0, frame_bits}, 32'h0000F7FF);

        // Host capture loop for 15'h5A58.
        i_btn_state = 15'h5A58;
        latch_pulse();
        host_word = '0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) clk_pulse();
            host_word[14 - k] = ~o_snes_data;
        end
        for (int k = 12; k < 16; k++) begin
            clk_pulse();
        end
        chk("host_word", {17'd0, host_word}, 32'h00005A58);

        // Abort mid-frame with a second latch.
        i_btn_state = 15'h0008;
        done_base   = done_pulses;
        latch_pulse();
        for (int k = 0; k < 5; k++) clk_pulse();
        chk("abort_cnt5", {27'd0, o_bit_cnt}, 32'd5);
        i_btn_state = 15'h4000;
        latch_pulse();
        chk("abort_cnt0", {27'd0, o_bit_cnt}, 32'd0);
        chk("abort_bit0", {31'd0, o_snes_data}, 32'd0);
        chk("abort_no_done", done_pulses - done_base, 0);

        // Reset mid-frame.
        i_btn_state = 15'h4000;
        latch_pulse();
        for (int k = 0; k < 7; k++) clk_pulse();
        chk("rstmid_cnt7", {27'd0, o_bit_cnt}, 32'd7);
        i_rst = 1'b1;
        tick(1);
        chk("rstmid_data", {31'd0, o_snes_data}, 32'd1);
        chk("rstmid_cnt", {27'd0, o_bit_cnt}, 32'd0);
        tick(2);
        i_rst = 1'b0;
        latch_base = latch_pulses;
        tick(10);
        chk("rstmid_no_latch_pls", latch_pulses - latch_base, 0);
        clk_pulse();
        chk("rstmid_idle_cnt", {27'd0, o_bit_cnt}, 32'd0);
        chk("rstmid_idle_data", {31'd0, o_snes_data}, 32'd1);

        // Twenty clocks after one latch: saturate at 16, one done pulse.
        i_btn_state = 15'h5A58;
        done_base   = done_pulses;
        latch_pulse();
        for (int k = 0; k < 20; k++) clk_pulse();
        chk("sat_cnt", {27'd0, o_bit_cnt}, 32'd16);
        chk("sat_done_once", done_pulses - done_base, 1);
        chk("sat_fill", {31'd0, o_snes_data}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
